// File: rtl/gray_step_sched.sv
// gray_step_sched: two-requester scheduler stepping a shared 3-bit Gray counter.
// Define GSS_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module gray_step_sched #(
  parameter int unsigned GAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] dir,
  input  logic [2:0] cnt0,
  input  logic [2:0] cnt1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic       step_en,
  output logic       up,
  output logic [2:0] qgray
);
  typedef enum logic [1:0] {IDLE, STEP, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [2:0] rem;
  logic [1:0] gap_cnt;
  logic       win;
  logic [2:0] cnt_w;
  logic       grant;
  assign grant = (state == IDLE) && (|req);
  assign cnt_w = win ? cnt1 : cnt0;
`ifdef GSS_ROUND_ROBIN_EN
  logic ptr;
  assign win = (&req) ? ptr : req[1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= 1'b0;
    else if (grant) ptr <= ~win;
`else
  assign win = ~req[0];
`endif
  function automatic logic [2:0] next_gray(input logic [2:0] g, input logic u);
    logic [2:0] b;
    b = {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    b = u ? b + 3'd1 : b - 3'd1;
    return b ^ (b >> 1);
  endfunction
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = (|req) ? ((cnt_w == 3'd0) ? DONE : STEP) : IDLE;
      STEP: state_n = (rem == 3'd1) ? DONE : ((GAP > 0) ? WAIT : STEP);
      WAIT: state_n = (gap_cnt == 2'(GAP - 1)) ? STEP : WAIT;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      qgray   <= 3'd0;
      gnt     <= 2'b00;
      up      <= 1'b0;
      rem     <= 3'd0;
      gap_cnt <= 2'd0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          gnt <= win ? 2'b10 : 2'b01;
          up  <= dir[win];
          rem <= cnt_w;
        end
        STEP: begin
          qgray   <= next_gray(qgray, up);
          rem     <= rem - 3'd1;
          gap_cnt <= 2'd0;
        end
        WAIT: gap_cnt <= gap_cnt + 2'd1;
        DONE: gnt <= 2'b00;
        default: gnt <= 2'b00;
      endcase
    end
  always_comb begin
    busy    = state != IDLE;
    step_en = state == STEP;
    done    = (state == DONE) ? gnt : 2'b00;
  end
endmodule

// File: tb/tb_gray_step_sched.sv
// tb_gray_step_sched: GAP=0 and GAP=2 instances checked every cycle against an operation-level model.
module tb_gray_step_sched;
  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       step_en;
    logic       up;
    logic [2:0] qgray;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00, dir = 2'b00;
  logic [2:0] cnt0 = 3'd0, cnt1 = 3'd0;
  logic [1:0] gnt_o [2];
  logic [1:0] done_o [2];
  logic       busy_o [2], step_o [2], up_o [2];
  logic [2:0] q_o [2];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  gray_step_sched #(.GAP(0)) u0 (.clk(clk), .reset(reset), .req(req), .dir(dir), .cnt0(cnt0), .cnt1(cnt1),
    .gnt(gnt_o[0]), .done(done_o[0]), .busy(busy_o[0]), .step_en(step_o[0]), .up(up_o[0]), .qgray(q_o[0]));
  gray_step_sched #(.GAP(2)) u1 (.clk(clk), .reset(reset), .req(req), .dir(dir), .cnt0(cnt0), .cnt1(cnt1),
    .gnt(gnt_o[1]), .done(done_o[1]), .busy(busy_o[1]), .step_en(step_o[1]), .up(up_o[1]), .qgray(q_o[1]));

  // Model: the Gray code at each position of the up sequence; an operation is planned as a list of cycles.
  logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  obs_t       plan_q [2][$];
  logic [2:0] pos_m [2];
  logic       up_m [2];
  logic       ptr_m [2];

  function automatic obs_t o(logic [1:0] g, logic [1:0] d, logic b, logic s, logic u, logic [2:0] q);
    return '{g, d, b, s, u, q};
  endfunction

  function automatic obs_t act(int i);
    return '{gnt_o[i], done_o[i], busy_o[i], step_o[i], up_o[i], q_o[i]};
  endfunction

  function automatic obs_t cur(int i);
    return plan_q[i].size() != 0 ? plan_q[i][0] : o(2'b00, 2'b00, 1'b0, 1'b0, up_m[i], seq[pos_m[i]]);
  endfunction

  task automatic check(string name, int i, obs_t a, obs_t e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s inst%0d got gnt=%b done=%b busy=%b step=%b up=%b q=%b want gnt=%b done=%b busy=%b step=%b up=%b q=%b",
                  name, i, a.gnt, a.done, a.busy, a.step_en, a.up, a.qgray,
                  e.gnt, e.done, e.busy, e.step_en, e.up, e.qgray);
  endtask

  task automatic lit(string name, int i, obs_t e);
    check(name, i, act(i), e);
  endtask

  task automatic plan(int i);
    int w, n, gap;
    logic [1:0] g;
    gap = (i == 0) ? 0 : 2;
`ifdef GSS_ROUND_ROBIN_EN
    w = (req == 2'b11) ? int'(ptr_m[i]) : (req[0] ? 0 : 1);
`else
    w = req[0] ? 0 : 1;
`endif
    ptr_m[i] = (w == 0);
    g = (w == 0) ? 2'b01 : 2'b10;
    n = (w == 0) ? int'(cnt0) : int'(cnt1);
    up_m[i] = dir[w];
    for (int k = 0; k < n; k++) begin
      plan_q[i].push_back(o(g, 2'b00, 1'b1, 1'b1, up_m[i], seq[pos_m[i]]));
      pos_m[i] = up_m[i] ? pos_m[i] + 3'd1 : pos_m[i] - 3'd1;
      if (k < n - 1)
        for (int j = 0; j < gap; j++) plan_q[i].push_back(o(g, 2'b00, 1'b1, 1'b0, up_m[i], seq[pos_m[i]]));
    end
    plan_q[i].push_back(o(g, g, 1'b1, 1'b0, up_m[i], seq[pos_m[i]]));
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    for (int i = 0; i < 2; i++)
      if (!reset) begin
        plan_q[i].delete();
        pos_m[i] = 3'd0;
        up_m[i]  = 1'b0;
        ptr_m[i] = 1'b0;
      end else if (plan_q[i].size() != 0) void'(plan_q[i].pop_front());
      else if (req != 2'b00) plan(i);
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("cycle", i, act(i), cur(i));
  end

  task automatic do_reset();
    req = 2'b00;
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    lit("reset_state", 0, '0);
    lit("reset_state", 1, '0);
    #1 reset = 1'b1;
    req = 2'b01; dir = 2'b01; cnt0 = 3'd3; cnt1 = 3'd0;
    @(negedge clk); lit("up3_s1", 0, o(2'b01, 2'b00, 1, 1, 1, 3'b000)); #1 req = 2'b00;
    @(negedge clk); lit("up3_s2", 0, o(2'b01, 2'b00, 1, 1, 1, 3'b001));
    @(negedge clk); lit("up3_s3", 0, o(2'b01, 2'b00, 1, 1, 1, 3'b011));
    @(negedge clk); lit("up3_done", 0, o(2'b01, 2'b01, 1, 0, 1, 3'b010));
    @(negedge clk); lit("up3_idle", 0, o(2'b00, 2'b00, 0, 0, 1, 3'b010));
    do_reset();
    req = 2'b10; dir = 2'b00; cnt1 = 3'd2;
    @(negedge clk); lit("dn2_s1", 0, o(2'b10, 2'b00, 1, 1, 0, 3'b000)); #1 req = 2'b00;
    @(negedge clk); lit("dn2_s2", 0, o(2'b10, 2'b00, 1, 1, 0, 3'b100));
    @(negedge clk); lit("dn2_done", 0, o(2'b10, 2'b10, 1, 0, 0, 3'b101));
    @(negedge clk); lit("dn2_idle", 0, o(2'b00, 2'b00, 0, 0, 0, 3'b101));
    #1 req = 2'b01; dir = 2'b01; cnt0 = 3'd0;
    @(negedge clk); lit("zero_done", 0, o(2'b01, 2'b01, 1, 0, 1, 3'b101)); #1 req = 2'b00;
    @(negedge clk); lit("zero_idle", 0, o(2'b00, 2'b00, 0, 0, 1, 3'b101));
    do_reset();
    req = 2'b11; dir = 2'b11; cnt0 = 3'd1; cnt1 = 3'd1;
    @(negedge clk); lit("arb_a_step", 0, o(2'b01, 2'b00, 1, 1, 1, 3'b000));
    @(negedge clk); lit("arb_a_done", 0, o(2'b01, 2'b01, 1, 0, 1, 3'b001));
    @(negedge clk); lit("arb_idle", 0, o(2'b00, 2'b00, 0, 0, 1, 3'b001));
`ifdef GSS_ROUND_ROBIN_EN
    @(negedge clk); lit("arb_b_step", 0, o(2'b10, 2'b00, 1, 1, 1, 3'b001)); #1 req = 2'b00;
    @(negedge clk); lit("arb_b_done", 0, o(2'b10, 2'b10, 1, 0, 1, 3'b011));
`else
    @(negedge clk); lit("arb_b_step", 0, o(2'b01, 2'b00, 1, 1, 1, 3'b001)); #1 req = 2'b00;
    @(negedge clk); lit("arb_b_done", 0, o(2'b01, 2'b01, 1, 0, 1, 3'b011));
`endif
    do_reset();
    req = 2'b01; dir = 2'b01; cnt0 = 3'd5;
    @(negedge clk); #1 req = 2'b00;
    @(negedge clk);
    @(negedge clk); lit("pre_reset", 0, o(2'b01, 2'b00, 1, 1, 1, 3'b011));
    #1 reset = 1'b0;
    #1 lit("async_reset", 0, '0);
    @(negedge clk); #1 reset = 1'b1;
    req = 2'b01; dir = 2'b01; cnt0 = 3'd2;
    @(negedge clk); lit("gap_s1", 1, o(2'b01, 2'b00, 1, 1, 1, 3'b000)); #1 req = 2'b00;
    @(negedge clk); lit("gap_w1", 1, o(2'b01, 2'b00, 1, 0, 1, 3'b001));
    @(negedge clk); lit("gap_w2", 1, o(2'b01, 2'b00, 1, 0, 1, 3'b001));
    @(negedge clk); lit("gap_s2", 1, o(2'b01, 2'b00, 1, 1, 1, 3'b001));
    @(negedge clk); lit("gap_done", 1, o(2'b01, 2'b01, 1, 0, 1, 3'b011));
    @(negedge clk); lit("gap_idle", 1, o(2'b00, 2'b00, 0, 0, 1, 3'b011));
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      req   = 2'($urandom_range(0, 3));
      dir   = 2'($urandom_range(0, 3));
      cnt0  = 3'($urandom_range(0, 7));
      cnt1  = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
